i2c_bus_sequencer: RTL and testbench

- Owns the byte-level I2C engine and sequences it.
- After reset it replays a register table of (register, value) pairs to the audio DAC/codec as 3-byte write transactions, with NACK retry.
- Afterwards it grants the bus to the SPI-to-I2C bridge (host) on request and revokes it on release or inactivity timeout.
- Sits between the SPI bridge, an external config ROM and the I2C engine in top.

---
 rtl/i2c_bus_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_i2c_bus_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_sequencer
//  Description : Sequences the byte-level I2C engine. After reset it replays
//                a (register, value) table from an external ROM to the codec
//                as 3-byte write transactions, with bounded NACK retry. Once
//                the table is done, the bus is lent to the SPI-to-I2C bridge
//                on request and taken back on release or inactivity timeout.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset      : system clock, synchronous active-high reset
//    tbl_idx         : config ROM address
//    tbl_data        : ROM word (combinational), [15:8] register, [7:0] value
//    boot_restart    : pulse, re-run the table (honoured only when idle)
//    eng_valid/data/last, eng_ready : byte stream into the I2C engine
//    eng_done, eng_nack             : end-of-transaction pulse and status
//    host_req/gnt    : bridge bus request / grant
//    host_valid/data/last, host_ready, host_done : bridge byte stream
//    init_done       : table replay finished (sticky until restart)
//    init_err        : an entry ran out of retries (sticky until restart)
// ============================================================================
module i2c_bus_sequencer #(
    parameter logic [6:0] DEV_ADDR     = 7'h1A,
    parameter int         N_REGS       = 10,
    parameter int         IDXW         = 4,
    parameter int         RETRIES      = 3,
    parameter int         GAP_CYCLES   = 250,
    parameter int         HOLD_TIMEOUT = 25000000
) (
    input  logic            clk,
    input  logic            reset,
    // config ROM
    output logic [IDXW-1:0] tbl_idx,
    input  logic [15:0]     tbl_data,
    input  logic            boot_restart,
    // I2C engine
    output logic            eng_valid,
    output logic [7:0]      eng_data,
    output logic            eng_last,
    input  logic            eng_ready,
    input  logic            eng_done,
    input  logic            eng_nack,
    // SPI bridge (host)
    input  logic            host_req,
    output logic            host_gnt,
    input  logic            host_valid,
    input  logic [7:0]      host_data,
    input  logic            host_last,
    output logic            host_ready,
    output logic            host_done,
    // status
    output logic            init_done,
    output logic            init_err
);

    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_TIMEOUT + 1);
    localparam int RTY_W  = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TIMEOUT - 1);
    localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(RETRIES);
    localparam logic [IDXW-1:0]   IDX_LAST  = IDXW'(N_REGS - 1);

    typedef enum logic [2:0] {
        ST_LOAD = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_IDLE = 3'd4,
        ST_HOST = 3'd5
    } state_t;

    state_t            state_q,     state_d;
    logic [IDXW-1:0]   idx_q,       idx_d;
    logic [1:0]        byte_q,      byte_d;
    logic [RTY_W-1:0]  retry_q,     retry_d;
    logic [GAP_W-1:0]  gap_q,       gap_d;
    logic [HOLD_W-1:0] hold_q,      hold_d;
    logic              inflight_q,  inflight_d;
    logic              init_done_q, init_done_d;
    logic              init_err_q,  init_err_d;

    // Host-phase helpers
    logic w_host_hs;
    logic w_host_busy;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            byte_q      <= '0;
            retry_q     <= '0;
            gap_q       <= '0;
            hold_q      <= '0;
            inflight_q  <= 1'b0;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            byte_q      <= byte_d;
            retry_q     <= retry_d;
            gap_q       <= gap_d;
            hold_q      <= hold_d;
            inflight_q  <= inflight_d;
            init_done_q <= init_done_d;
            init_err_q  <= init_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        byte_d      = byte_q;
        retry_d     = retry_q;
        gap_d       = gap_q;
        hold_d      = hold_q;
        inflight_d  = inflight_q;
        init_done_d = init_done_q;
        init_err_d  = init_err_q;

        eng_valid   = 1'b0;
        eng_data    = 8'h00;
        eng_last    = 1'b0;
        host_ready  = 1'b0;
        host_done   = 1'b0;
        w_host_hs   = 1'b0;
        w_host_busy = 1'b0;

        unique case (state_q)
            // One cycle for the ROM word at idx_q to settle.
            ST_LOAD: begin
                byte_d  = 2'd0;
                state_d = ST_SEND;
            end

            // Address byte, register byte, value byte; STOP after the value.
            ST_SEND: begin
                eng_valid = 1'b1;
                case (byte_q)
                    2'd0:    eng_data = {DEV_ADDR, 1'b0};
                    2'd1:    eng_data = tbl_data[15:8];
                    default: begin
                        eng_data = tbl_data[7:0];
                        eng_last = 1'b1;
                    end
                endcase
                if (eng_ready) begin
                    if (eng_last) begin
                        state_d = ST_WAIT;
                    end else begin
                        byte_d = byte_q + 2'd1;
                    end
                end
            end

            ST_WAIT: begin
                if (eng_done) begin
                    gap_d = '0;
                    if (eng_nack && (retry_q != RTY_MAX)) begin
                        // Retry the same entry after the gap.
                        retry_d = retry_q + RTY_W'(1);
                        state_d = ST_GAP;
                    end else begin
                        // Success, or retries exhausted: flag it and move on
                        // so the rest of the table is still programmed.
                        retry_d = '0;
                        if (eng_nack) begin
                            init_err_d = 1'b1;
                        end
                        if (idx_q == IDX_LAST) begin
                            init_done_d = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            idx_d   = idx_q + IDXW'(1);
                            state_d = ST_GAP;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_LOAD;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            // A restart request outranks a pending host request.
            ST_IDLE: begin
                if (boot_restart) begin
                    init_done_d = 1'b0;
                    init_err_d  = 1'b0;
                    idx_d       = '0;
                    retry_d     = '0;
                    state_d     = ST_LOAD;
                end else if (host_req) begin
                    hold_d     = '0;
                    inflight_d = 1'b0;
                    state_d    = ST_HOST;
                end
            end

            ST_HOST: begin
                eng_valid  = host_valid;
                eng_data   = host_data;
                eng_last   = host_last;
                host_ready = eng_ready;
                host_done  = eng_done;

                w_host_hs  = host_valid & eng_ready;
                // In flight from the final byte's handshake until eng_done.
                // A final byte accepted this very cycle already counts, so
                // a simultaneous request drop cannot cut the transaction.
                w_host_busy = (inflight_q & ~eng_done) | (w_host_hs & host_last);
                inflight_d  = w_host_busy;

                if (w_host_hs || w_host_busy) begin
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end

                if (!w_host_busy &&
                    (!host_req || (!w_host_hs && (hold_q == HOLD_LAST)))) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    assign tbl_idx   = idx_q;
    assign host_gnt  = (state_q == ST_HOST);
    assign init_done = init_done_q;
    assign init_err  = init_err_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_bus_sequencer
//  Description : Self-checking bench for i2c_bus_sequencer. A behavioural
//                engine model accepts bytes and answers with done/nack; the
//                expected byte stream and nack answers are queued from the
//                table contents and a per-entry NACK plan.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_sequencer;

    localparam logic [6:0] DEV_ADDR     = 7'h1A;
    localparam int         N_REGS       = 3;
    localparam int         IDXW         = 4;
    localparam int         RETRIES      = 3;
    localparam int         GAP_CYCLES   = 4;
    localparam int         HOLD_TIMEOUT = 100;

    logic            clk = 1'b0;
    logic            reset;
    logic [IDXW-1:0] tbl_idx;
    logic [15:0]     tbl_data;
    logic            boot_restart;
    logic            eng_valid;
    logic [7:0]      eng_data;
    logic            eng_last;
    logic            eng_ready;
    logic            eng_done;
    logic            eng_nack;
    logic            host_req;
    logic            host_gnt;
    logic            host_valid;
    logic [7:0]      host_data;
    logic            host_last;
    logic            host_ready;
    logic            host_done;
    logic            init_done;
    logic            init_err;

    logic [15:0] rom [16];
    int          nack_plan [N_REGS];
    logic [8:0]  exp_q [$];
    bit          nack_q [$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int done_cyc = 0;
    int pos = 0;

    assign tbl_data = rom[tbl_idx];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_bus_sequencer #(
        .DEV_ADDR    (DEV_ADDR),
        .N_REGS      (N_REGS),
        .IDXW        (IDXW),
        .RETRIES     (RETRIES),
        .GAP_CYCLES  (GAP_CYCLES),
        .HOLD_TIMEOUT(HOLD_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tbl_idx     (tbl_idx),
        .tbl_data    (tbl_data),
        .boot_restart(boot_restart),
        .eng_valid   (eng_valid),
        .eng_data    (eng_data),
        .eng_last    (eng_last),
        .eng_ready   (eng_ready),
        .eng_done    (eng_done),
        .eng_nack    (eng_nack),
        .host_req    (host_req),
        .host_gnt    (host_gnt),
        .host_valid  (host_valid),
        .host_data   (host_data),
        .host_last   (host_last),
        .host_ready  (host_ready),
        .host_done   (host_done),
        .init_done   (init_done),
        .init_err    (init_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected traffic for one table replay: each entry is attempted once
    // plus once per NACK, up to RETRIES extra attempts.
    task automatic build_boot(output bit err);
        err = 1'b0;
        for (int i = 0; i < N_REGS; i++) begin
            int n;
            int att;
            n   = nack_plan[i];
            att = ((n > RETRIES) ? RETRIES : n) + 1;
            if (n > RETRIES) err = 1'b1;
            for (int k = 0; k < att; k++) begin
                exp_q.push_back({1'b0, DEV_ADDR, 1'b0});
                exp_q.push_back({1'b0, rom[i][15:8]});
                exp_q.push_back({1'b1, rom[i][7:0]});
                nack_q.push_back(k < n);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Engine model + scoreboard monitor
    // ------------------------------------------------------------------
    initial begin : engine
        int  pend;
        bit  gap_armed;
        bit  prev_valid;
        logic [8:0] e;
        pend = 0; gap_armed = 0; prev_valid = 0;
        eng_ready = 1'b0; eng_done = 1'b0; eng_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 0; pos = 0; gap_armed = 0; prev_valid = 0;
            end else begin
                check("host_ready_mirror", 32'(host_ready), 32'(host_gnt & eng_ready));
                check("host_done_mirror",  32'(host_done),  32'(host_gnt & eng_done));
                if (eng_done) begin
                    done_cyc = cyc;
                    gap_armed = !host_gnt;
                end
                if (init_done) gap_armed = 0;
                if (gap_armed && eng_valid && !prev_valid) begin
                    check("gap_length", 32'(cyc - done_cyc), 32'(GAP_CYCLES + 2));
                    gap_armed = 0;
                end
                if (eng_valid && eng_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", 32'({eng_last, eng_data}), 32'h1000);
                    end else begin
                        e = exp_q.pop_front();
                        check("eng_byte", 32'({eng_last, eng_data}), 32'(e));
                    end
                    pos++;
                    if (eng_last) begin
                        pos  = 0;
                        pend = int'($urandom_range(1, 4));
                    end
                end
                if (!eng_valid) pos = 0;
                prev_valid = eng_valid;
            end
            @(posedge clk); #2;
            eng_ready = ($urandom_range(0, 3) != 0);
            eng_done  = 1'b0;
            eng_nack  = 1'b0;
            if (!reset && pend > 0) begin
                pend--;
                if (pend == 0) begin
                    eng_done = 1'b1;
                    if (nack_q.size() == 0) check("nack_underflow", 32'd1, 32'd0);
                    else eng_nack = nack_q.pop_front();
                end
            end
        end
    end

    // Waits for a table replay to finish and checks its outcome.
    task automatic wait_boot(input bit exp_err);
        int c;
        int bad;
        c = 0; bad = 0;
        while (!init_done && c < 4000) begin
            if (host_gnt || host_ready) bad++;
            @(negedge clk); #1;
            c++;
        end
        check("boot_finished", 32'(init_done), 32'd1);
        check("init_done_latency", 32'(cyc - done_cyc), 32'd1);
        check("host_holdoff", 32'(bad), 32'd0);
        check("init_err", 32'(init_err), 32'(exp_err));
        check("bytes_drained", 32'(exp_q.size()), 32'd0);
        check("nacks_drained", 32'(nack_q.size()), 32'd0);
    endtask

    task automatic host_send(input logic [7:0] d, input logic l);
        int c;
        @(posedge clk); #2;
        host_valid = 1'b1; host_data = d; host_last = l;
        c = 0;
        do begin
            @(negedge clk); #1;
            c++;
        end while (!(host_valid && host_ready) && c < 100);
        check("host_byte_accepted", 32'(host_ready), 32'd1);
    endtask

    // Requests the bus, optionally offers one non-final byte at grant cycle
    // byte_at, and measures how many cycles the grant lasts.
    task automatic host_hold(input int byte_at, output int gnt_cycles, output int acc);
        int c;
        logic [7:0] d;
        acc = -1;
        @(posedge clk); #2;
        host_req = 1'b1;
        c = 0;
        do begin
            @(negedge clk); #1;
            c++;
        end while (!host_gnt && c < 20);
        check("hold_granted", 32'(host_gnt), 32'd1);
        c = 0;
        while (host_gnt && c < 1000) begin
            if (host_valid && host_ready) acc = c;
            @(posedge clk); #2;
            if (acc >= 0) begin
                host_valid = 1'b0;
            end else if (byte_at >= 0 && c + 1 == byte_at) begin
                d = 8'($urandom);
                exp_q.push_back({1'b0, d});
                host_valid = 1'b1; host_data = d; host_last = 1'b0;
            end
            @(negedge clk); #1;
            c++;
        end
        gnt_cycles = c;
        @(posedge clk); #2;
        host_req = 1'b0; host_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("hold_released", 32'(host_gnt), 32'd0);
    endtask

    task automatic restart(input bit exp_err);
        @(posedge clk); #2;
        boot_restart = 1'b1;
        @(posedge clk); #2;
        boot_restart = 1'b0;
        @(negedge clk); #1;
        check("restart_clears_done", 32'(init_done), 32'd0);
        check("restart_clears_err",  32'(init_err),  32'd0);
        check("restart_idx",         32'(tbl_idx),   32'd0);
        wait_boot(exp_err);
    endtask

    initial begin : main
        bit err;
        int c;
        int gc;
        int acc;

        reset = 1'b1; boot_restart = 1'b0;
        host_req = 1'b1; host_valid = 1'b0; host_data = 8'h00; host_last = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
        rom[0] = 16'h1E00; rom[1] = 16'h0C00; rom[2] = 16'h0E4A;
        for (int i = 0; i < N_REGS; i++) nack_plan[i] = 0;
        build_boot(err);

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_tbl_idx",    32'(tbl_idx),    32'd0);
        check("rst_eng_valid",  32'(eng_valid),  32'd0);
        check("rst_eng_data",   32'(eng_data),   32'd0);
        check("rst_eng_last",   32'(eng_last),   32'd0);
        check("rst_host_gnt",   32'(host_gnt),   32'd0);
        check("rst_host_ready", 32'(host_ready), 32'd0);
        check("rst_host_done",  32'(host_done),  32'd0);
        check("rst_init_done",  32'(init_done),  32'd0);
        check("rst_init_err",   32'(init_err),   32'd0);
        reset = 1'b0;

        // Clean boot with the host requesting throughout.
        wait_boot(err);
        c = 0;
        do begin
            @(negedge clk); #1;
            c++;
        end while (!host_gnt && c < 20);
        check("gnt_after_init_done", 32'(c), 32'd1);

        // Host transaction 34 05 7F, request dropped before eng_done.
        exp_q.push_back(9'h034); exp_q.push_back(9'h005); exp_q.push_back(9'h17F);
        nack_q.push_back(1'b0);
        host_send(8'h34, 1'b0);
        host_send(8'h05, 1'b0);
        host_send(8'h7F, 1'b1);
        @(posedge clk); #2;
        host_valid = 1'b0; host_last = 1'b0; host_req = 1'b0;
        c = 0; gc = 0;
        forever begin
            @(negedge clk); #1;
            c++;
            if (eng_done || c > 50) break;
            if (!host_gnt) gc++;
        end
        check("host_eng_done_seen",  32'(eng_done),  32'd1);
        check("gnt_held_in_flight",  32'(gc),        32'd0);
        check("gnt_at_eng_done",     32'(host_gnt),  32'd1);
        check("host_done_at_done",   32'(host_done), 32'd1);
        @(negedge clk); #1;
        check("gnt_after_done", 32'(host_gnt), 32'd0);
        check("host_bytes_drained", 32'(exp_q.size()), 32'd0);

        // Inactivity timeout, then timeout restarted by an accepted byte.
        host_hold(-1, gc, acc);
        check("timeout_no_bytes", 32'(gc), 32'(HOLD_TIMEOUT));
        host_hold(60, gc, acc);
        check("timeout_byte_accepted", 32'(acc >= 60), 32'd1);
        check("timeout_restarted", 32'(gc), 32'(acc + HOLD_TIMEOUT + 1));
        check("timeout_byte_drained", 32'(exp_q.size()), 32'd0);

        // Entry 1 exhausts its retries; the rest still gets sent.
        nack_plan[0] = 0; nack_plan[1] = 4; nack_plan[2] = 0;
        build_boot(err);
        restart(err);

        // Entry 1 NACKed twice then ACKed.
        nack_plan[1] = 2;
        build_boot(err);
        restart(err);

        // Randomised tables and NACK plans.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N_REGS; i++) begin
                rom[i] = 16'($urandom);
                nack_plan[i] = int'($urandom_range(0, 5));
            end
            build_boot(err);
            restart(err);
        end

        // Reset while the register byte is being offered.
        for (int i = 0; i < N_REGS; i++) begin
            rom[i] = 16'($urandom);
            nack_plan[i] = 0;
        end
        build_boot(err);
        @(posedge clk); #2;
        boot_restart = 1'b1;
        @(posedge clk); #2;
        boot_restart = 1'b0;
        c = 0;
        do begin
            @(negedge clk); #1;
            c++;
        end while (!(eng_valid && pos == 1) && c < 200);
        check("reached_byte1", 32'(pos), 32'd1);
        reset = 1'b1;
        @(negedge clk); #1;
        check("midrst_outputs",
              32'({tbl_idx, eng_valid, eng_data, eng_last, host_gnt,
                   host_ready, host_done, init_done, init_err}), 32'd0);
        exp_q.delete();
        nack_q.delete();
        build_boot(err);
        reset = 1'b0;
        wait_boot(err);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
